ariscv_ring_ctrl: RTL
=====================

Name: ariscv_ring_ctrl

Overview:
Clocked, parametrised successor to the fixed 6-stage self-timed control path. It emulates an N-stage ring of WCHB handshake cells for FPGA prototyping and for reproducible bring-up. Each stage holds a token flag, and each stage-to-stage link has a runtime-programmable delay in clock cycles. When a token moves into a stage, that stage's o_aclk bit pulses for one cycle; the datapath stages use these pulses as their register enables. Deadlock is detected and flagged.

Parameters:
N_STAGES, 6, number of ring stages/links (>=2)
DLY_W, 4, width of each per-link delay field and counter
INIT_TOKENS, 6'b010101, per-stage token flag loaded at reset (width N_STAGES)

Ports:
clk  input  1  system clock
rst_async_n  input  1  asynchronous active-low reset
i_en  input  1  global run enable; when 0, counters and tokens hold
i_dly  input  N_STAGES*DLY_W  delay of link i (stage i -> stage (i+1)%N) in bits [i*DLY_W +: DLY_W]
o_aclk  output  N_STAGES  one-cycle pulse per stage on token arrival
o_full  output  N_STAGES  current token flags
o_deadlock  output  1  registered: no link eligible in the previous cycle

Behaviour:
- Reset (async assert, sync to clk on deassert handled upstream):
  - full <= INIT_TOKENS
  - all link counters <= 0
  - o_aclk <= 0
  - o_deadlock <= 0
- Link i is eligible when full[i]==1, full[(i+1)%N]==0 and i_en==1. Eligibility uses registered state only, so there is no same-cycle pass-through.
- Per-link counter cnt[i] (DLY_W bits), updated each cycle:
  - not eligible -> cnt <= 0
  - eligible and cnt >= dly[i] -> fire; cnt <= 0
  - eligible otherwise -> cnt <= cnt+1
- The comparison is >=, so lowering i_dly mid-count fires on the next eligible cycle. The counter never exceeds 2^DLY_W-1, so there is no wrap.
- Timing: a link first eligible in cycle k fires in cycle k+dly[i]. The effect is visible after the clock edge ending that cycle.
- On fire of link i: full[i] <= 0, full[(i+1)%N] <= 1, o_aclk[(i+1)%N] <= 1 for exactly one cycle. o_aclk bits that did not fire are 0.
- Simultaneous fires on disjoint links are all applied in the same edge.
  - A stage cannot both receive and send in one cycle: send needs full=1, receive needs full=0.
  - Receive into stage j and send out of stage j-1 are the same event.
- i_en==0: no fires, o_aclk all 0, counters reset to 0 (the delay restarts after re-enable), full held.
- Deadlock: o_deadlock <= (no link eligible ignoring i_en). This occurs with all-full or all-empty token patterns.
  - It is computed regardless of i_en and is sticky only while the condition persists.
  - With INIT_TOKENS all 0 or all 1, o_deadlock is 1 from the first edge after reset.
- Reset asserted mid-operation: all state returns to reset values immediately; pending counts are discarded.
- N_STAGES==2 with tokens 2'b01: the single token ping-pongs; links alternate eligibility.

Decomposition:
- Package ariscv_ctrl_pkg:
  - default delay width constant
  - typedef for the delay field (logic [DLY_W-1:0] via a parametrised localparam pattern)
  - function next_idx(i,N) returning (i+1)%N
- Sub-module ariscv_ring_link: one link's counter and fire logic.
  - Inputs: src_full, dst_full, en, dly.
  - Output: fire.
  - Instantiated N_STAGES times by generate.
- The top level holds the full flags, o_aclk and the deadlock register.

Test Plan:
- N=6, INIT 010101, all dly=0, en=1 -> first edge after reset: o_aclk=101010, full=101010. Next edge: o_aclk=010101, full=010101. Alternation continues every cycle.
- Same setup with dly[0]=3, others 0:
  - links 2 and 4 fire at cycle 1; link 0 fires at cycle 4.
  - o_aclk[1] is first high 4 cycles after reset release.
  - No token is lost: popcount(full)==3 always.
- INIT 000000 -> o_deadlock=1 after the first edge, o_aclk stays 0. INIT 111111 gives the same result.
- Drop i_en for 5 cycles mid-run with dly=2 -> full frozen, o_aclk=0. After re-enable, the first fire occurs 2 cycles after eligibility resumes.
- Change dly[2] from 15 to 1 when cnt[2]=5 -> link 2 fires on the next cycle.
- Assert rst_async_n mid-count, without a clock edge -> full==INIT_TOKENS and o_aclk==0 immediately. After release, timing restarts from zero.

Source files
------------

// File: rtl/ariscv_ctrl_pkg.sv
// ariscv_ctrl_pkg: shared constants, types and ring index helper for the ring controller.
package ariscv_ctrl_pkg;

    localparam int DLY_W_DEF = 4;

    typedef logic [DLY_W_DEF-1:0] dly_t;

    function automatic int next_idx(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/ariscv_ring_link.sv
// ariscv_ring_link: delay counter for one stage-to-stage link; fires once the link has waited dly cycles.
module ariscv_ring_link
    import ariscv_ctrl_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_full,
    input  logic             dst_full,
    input  logic             en,
    input  logic [DLY_W-1:0] dly,
    output logic             fire
);

    logic [DLY_W-1:0] cnt;
    logic             elig;

    assign elig = src_full & ~dst_full & en;
    // >= lets a lowered delay fire at once; cnt can only reach dly, so it never wraps
    assign fire = elig && (cnt >= dly);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (elig && !fire) ? cnt + 1'b1 : '0;
    end

endmodule

// File: rtl/ariscv_ring.sv
// ariscv_ring_ctrl: N-stage clocked emulation of a WCHB handshake ring with per-link delays,
// token-arrival pulses and deadlock detection.
module ariscv_ring_ctrl
    import ariscv_ctrl_pkg::*;
#(
    parameter int                  N_STAGES    = 6,
    parameter int                  DLY_W       = DLY_W_DEF,
    parameter logic [N_STAGES-1:0] INIT_TOKENS = 6'b010101
) (
    input  logic                      clk,
    input  logic                      rst_async_n,
    input  logic                      i_en,
    input  logic [N_STAGES*DLY_W-1:0] i_dly,
    output logic [N_STAGES-1:0]       o_aclk,
    output logic [N_STAGES-1:0]       o_full,
    output logic                      o_deadlock
);

    logic [N_STAGES-1:0] fire;
    logic [N_STAGES-1:0] arrive;
    logic [N_STAGES-1:0] can_move;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_link
        ariscv_ring_link #(.DLY_W(DLY_W)) u_link (
            .clk     (clk),
            .rst_n   (rst_async_n),
            .src_full(o_full[g]),
            .dst_full(o_full[next_idx(g, N_STAGES)]),
            .en      (i_en),
            .dly     (i_dly[g*DLY_W +: DLY_W]),
            .fire    (fire[g])
        );
        assign arrive[next_idx(g, N_STAGES)] = fire[g];
        // eligibility ignoring the run enable, so a paused ring is not reported as deadlocked
        assign can_move[g] = o_full[g] & ~o_full[next_idx(g, N_STAGES)];
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            o_full     <= INIT_TOKENS;
            o_aclk     <= '0;
            o_deadlock <= 1'b0;
        end else begin
            o_full     <= (o_full & ~fire) | arrive;
            o_aclk     <= arrive;
            o_deadlock <= ~|can_move;
        end
    end

endmodule
